// File: rtl/result_uart_tx_if.sv
// -----------------------------------------------------------------------------
// result_uart_tx_if
//   Byte handshake between the upstream adder stage and result_uart_tx.
//   result_in    : result byte offered by upstream
//   result_valid : result_in is offered this cycle
//   result_ready : downstream can accept a byte this cycle
//   master = upstream producer, slave = result_uart_tx
// -----------------------------------------------------------------------------
interface result_uart_tx_if;
   logic [7:0] result_in;
   logic       result_valid;
   logic       result_ready;

   modport master (
      output result_in,
      output result_valid,
      input  result_ready
   );

   modport slave (
      input  result_in,
      input  result_valid,
      output result_ready
   );
endinterface

// File: rtl/result_uart_tx.sv
// -----------------------------------------------------------------------------
// result_uart_tx
//   Serialises result bytes from the upstream adder stage onto a UART line
//   (start bit, 8 data bits LSB first, optional even parity, one stop bit).
//   A one-deep holding register decouples the upstream handshake from the
//   frame in flight, so a byte can be accepted while the previous one shifts.
//
//   Parameters
//     CLKS_PER_BIT : clock cycles per serial bit (2..1023)
//   Ports
//     clk          : single clock, rising edge
//     rst          : synchronous active-high reset
//     up           : result_uart_tx_if.slave (result_in, result_valid, result_ready)
//     tx           : serial line, idle high
//     busy         : a frame is being shifted
//     tx_done      : one-cycle pulse during the final stop-bit cycle
//     frame_count  : completed frames, wraps 255 -> 0
//   Build option
//     RESULT_UART_TX_PARITY_EN : adds an even-parity bit after data bit 7
// -----------------------------------------------------------------------------
module result_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   result_uart_tx_if.slave        up,
   output logic                   tx,
   output logic                   busy,
   output logic                   tx_done,
   output logic [7:0]             frame_count
);

   localparam logic [9:0] BAUD_RELOAD = 10'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef RESULT_UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t     r_state;
   logic [7:0] r_hold_data;
   logic       r_hold_full;
   logic [7:0] r_shift;
   logic [2:0] r_bit_idx;
   logic [9:0] r_baud;
   logic       r_tx;
   logic       r_tx_done;
   logic [7:0] r_frame_count;
`ifdef RESULT_UART_TX_PARITY_EN
   logic       r_parity;
`endif

   logic       w_accept;
   logic       w_baud_zero;

   // Ready comes straight from the hold flag, never from result_valid.
   assign w_accept    = up.result_valid && !r_hold_full;
   assign w_baud_zero = (r_baud == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_hold_data   <= '0;
         r_hold_full   <= 1'b0;
         r_shift       <= '0;
         r_bit_idx     <= '0;
         r_baud        <= '0;
         r_tx          <= 1'b1;
         r_tx_done     <= 1'b0;
         r_frame_count <= '0;
`ifdef RESULT_UART_TX_PARITY_EN
         r_parity      <= 1'b0;
`endif
      end else begin
         r_tx_done <= 1'b0;

         if (w_accept) begin
            r_hold_data <= up.result_in;
            r_hold_full <= 1'b1;
         end

         if (r_state != S_IDLE) begin
            r_baud <= w_baud_zero ? BAUD_RELOAD : r_baud - 10'd1;
         end

         case (r_state)
            S_IDLE: begin
               r_tx <= 1'b1;
               if (r_hold_full) begin
                  r_state     <= S_START;
                  r_shift     <= r_hold_data;
                  r_hold_full <= 1'b0;
                  r_tx        <= 1'b0;
                  r_baud      <= BAUD_RELOAD;
                  r_bit_idx   <= '0;
`ifdef RESULT_UART_TX_PARITY_EN
                  r_parity    <= ^r_hold_data;
`endif
               end
            end

            S_START: begin
               if (w_baud_zero) begin
                  r_state <= S_DATA;
                  r_tx    <= r_shift[0];
               end
            end

            S_DATA: begin
               if (w_baud_zero) begin
                  if (r_bit_idx == 3'd7) begin
`ifdef RESULT_UART_TX_PARITY_EN
                     r_state <= S_PARITY;
                     r_tx    <= r_parity;
`else
                     r_state <= S_STOP;
                     r_tx    <= 1'b1;
`endif
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_shift   <= {1'b0, r_shift[7:1]};
                     r_tx      <= r_shift[1];
                  end
               end
            end

`ifdef RESULT_UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_baud_zero) begin
                  r_state <= S_STOP;
                  r_tx    <= 1'b1;
               end
            end
`endif

            S_STOP: begin
               // Set one cycle early so the pulse coincides with the final
               // stop-bit cycle (counter at 0) while staying a flop output.
               if (r_baud == 10'd1) begin
                  r_tx_done <= 1'b1;
               end
               if (w_baud_zero) begin
                  r_state       <= S_IDLE;
                  r_frame_count <= r_frame_count + 8'd1;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign up.result_ready = ~r_hold_full;
   assign tx              = r_tx;
   assign busy            = (r_state != S_IDLE);
   assign tx_done         = r_tx_done;
   assign frame_count     = r_frame_count;

endmodule

// File: tb/tb_result_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_result_uart_tx
//   Directed stimulus for result_uart_tx (CLKS_PER_BIT = 4). The driver pushes
//   each accepted byte with its accept edge into a queue; an independent
//   monitor detects each start bit, pops the expected byte and checks the
//   whole frame cycle by cycle (line level, busy, tx_done timing, start
//   latency, frame_count after the frame, and aborts caused by reset).
// -----------------------------------------------------------------------------
module tb_result_uart_tx;

   localparam int CPB = 4;
`ifdef RESULT_UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FR = NB * CPB;

   typedef struct {
      logic [7:0] d;
      int         acc;
      bit         ab;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx;
   logic       busy;
   logic       tx_done;
   logic [7:0] frame_count;

   int   cyc      = 0;
   logic rst_q    = 1'b0;
   int   n_pass   = 0;
   int   n_tot    = 0;
   int   done_cnt = 0;
   bit   mon_busy = 1'b0;
   exp_t q[$];

   result_uart_tx_if u_if ();

   result_uart_tx #(.CLKS_PER_BIT(CPB)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .up          (u_if.slave),
      .tx          (tx),
      .busy        (busy),
      .tx_done     (tx_done),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   // Edge counter and "reset was applied at the last edge" flag.
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   always @(negedge clk) begin
      if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   function automatic logic expbit(input logic [7:0] d, input int b);
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
`ifdef RESULT_UART_TX_PARITY_EN
      if (b == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   // ---------------------------------------------------------------- monitor
   initial begin : monitor
      exp_t       it;
      int         s;
      int         es;
      int         last_start;
      logic [7:0] model_fc;
      bit         ok_bits;
      bit         ok_done;
      bit         aborted;
      last_start = -1000;
      model_fc   = '0;
      forever begin
         @(negedge clk);
         if (rst_q) begin
            model_fc   = '0;
            last_start = -1000;
         end else if (tx === 1'b0) begin
            mon_busy = 1'b1;
            s = cyc;
            if (q.size() == 0) begin
               n_tot++;
               $display("FAIL frame_unexpected: start bit at cycle %0d with empty queue", s);
               it.d = '0; it.acc = s - 1; it.ab = 1'b0;
            end else begin
               it = q.pop_front();
            end
            es = (it.acc + 1 > last_start + FR + 1) ? it.acc + 1 : last_start + FR + 1;
            chk("start_cycle", 32'(s), 32'(es));
            ok_bits = 1'b1;
            ok_done = 1'b1;
            aborted = 1'b0;
            for (int j = 0; j < FR; j++) begin
               if (j > 0) @(negedge clk);
               if (rst_q) begin
                  aborted = 1'b1;
                  break;
               end
               if (tx !== expbit(it.d, j / CPB)) ok_bits = 1'b0;
               if (busy !== 1'b1) ok_bits = 1'b0;
               if (tx_done !== ((j == FR - 1) ? 1'b1 : 1'b0)) ok_done = 1'b0;
            end
            chk("abort_expected", 32'(aborted), 32'(it.ab));
            chk("tx_done_timing", 32'(ok_done), 32'd1);
            if (aborted) begin
               model_fc   = '0;
               last_start = -1000;
            end else begin
               chk("frame_bits", 32'(ok_bits), 32'd1);
               @(negedge clk);
               model_fc = model_fc + 8'd1;
               chk("idle_tx", 32'(tx), 32'd1);
               chk("idle_busy", 32'(busy), 32'd0);
               chk("frame_count", 32'(frame_count), 32'(model_fc));
               last_start = s;
            end
            mon_busy = 1'b0;
         end
      end
   end

   // ----------------------------------------------------------------- driver
   task automatic send(input logic [7:0] d, input bit ab, output int acc);
      int unsigned w = 0;
      u_if.result_valid = 1'b1;
      u_if.result_in    = d;
      while (u_if.result_ready !== 1'b1 && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (w >= 500) begin
         n_tot++;
         $display("FAIL send_timeout: result_ready low for %0d cycles", w);
         u_if.result_valid = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc + 1;
      q.push_back('{d: d, acc: acc, ab: ab});
      @(negedge clk);
   endtask

   task automatic idle_in();
      u_if.result_valid = 1'b0;
   endtask

   task automatic drain();
      int unsigned w = 0;
      while ((q.size() != 0 || mon_busy) && w < 3000) begin
         @(negedge clk);
         w++;
      end
      if (w >= 3000) begin
         n_tot++;
         $display("FAIL drain_timeout: queue %0d monitor_busy %0d", q.size(), mon_busy);
      end
      @(negedge clk);
   endtask

   initial begin : driver
      int a, b, c, d0;
      u_if.result_valid = 1'b0;
      u_if.result_in    = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tx_done", 32'(tx_done), 32'd0);
      chk("rst_ready", 32'(u_if.result_ready), 32'd1);
      chk("rst_frame_count", 32'(frame_count), 32'd0);
      // reset wins over a simultaneous handshake
      u_if.result_valid = 1'b1;
      u_if.result_in    = 8'h99;
      @(negedge clk);
      idle_in();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_blocks_accept_ready", 32'(u_if.result_ready), 32'd1);
      chk("rst_blocks_accept_busy", 32'(busy), 32'd0);

      // abort during data bit 3 of 0x3C (bit 3 spans E+17..E+20)
      d0 = done_cnt;
      send(8'h3C, 1'b1, a);
      idle_in();
      while (cyc < a + 18) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_tx", 32'(tx), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(u_if.result_ready), 32'd1);
      chk("abort_frame_count", 32'(frame_count), 32'd0);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      chk("abort_no_tx_done", 32'(done_cnt - d0), 32'd0);
      chk("abort_stays_idle", 32'(busy), 32'd0);

      // single byte 0xA5
      d0 = done_cnt;
      send(8'hA5, 1'b0, a);
      idle_in();
      drain();
      chk("a5_frame_count", 32'(frame_count), 32'd1);
      chk("a5_tx_done_pulses", 32'(done_cnt - d0), 32'd1);

      // 0x01 then 0xFF with valid held continuously
      send(8'h01, 1'b0, a);
      send(8'hFF, 1'b0, b);
      idle_in();
      chk("b2b_second_accept", 32'(b - a), 32'd2);
      drain();
      chk("b2b_frame_count", 32'(frame_count), 32'd3);

      // three bytes offered back to back
      send(8'h11, 1'b0, a);
      send(8'h22, 1'b0, b);
      send(8'h33, 1'b0, c);
      idle_in();
      chk("three_second_accept", 32'(b - a), 32'd2);
      chk("three_third_accept", 32'(c - a), 32'd43);
      drain();
      chk("three_frame_count", 32'(frame_count), 32'd6);

`ifdef RESULT_UART_TX_PARITY_EN
      send(8'h07, 1'b0, a);
      idle_in();
      drain();
      send(8'h03, 1'b0, a);
      idle_in();
      drain();
      chk("parity_frame_count", 32'(frame_count), 32'd8);
`endif

      // 256 frames after a fresh reset: counter wraps to 0
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      d0 = done_cnt;
      for (int i = 0; i < 256; i++) begin
         send(8'(i * 37 + 5), 1'b0, a);
      end
      idle_in();
      drain();
      chk("wrap_frame_count", 32'(frame_count), 32'd0);
      chk("wrap_tx_done_pulses", 32'(done_cnt - d0), 32'd256);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/result_uart_tx.md
RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 2..1023.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 result_in  input  8  result byte from the upstream adder stage.
REQ-005 result_valid  input  1  result_in is offered this cycle.
REQ-006 result_ready  output  1  block can accept a byte this cycle.
REQ-007 tx  output  1  serial line, idle high, LSB first.
REQ-008 busy  output  1  a frame is being shifted (state other than IDLE).
REQ-009 tx_done  output  1  one-cycle pulse at the end of each stop bit.
REQ-010 frame_count  output  8  number of completed frames, wraps 255->0.

Function
REQ-011 One-deep holding register (hold_data, hold_full) buffers the upstream byte; result_ready SHALL equal !hold_full, driven from a flop with no combinational path from result_valid.
REQ-012 Handshake: byte accepted on an edge where result_valid && result_ready; hold_data<=result_in and hold_full<=1 on that edge; result_in is ignored when result_ready is low.
REQ-013 FSM states IDLE, START, DATA, PARITY (macro only), STOP; state, shift register, bit index, baud counter and tx are registered.
REQ-014 IDLE with hold_full=1: next edge enters START, loads shift register from hold_data, clears hold_full, drives tx=0, and loads baud counter with CLKS_PER_BIT-1.
REQ-015 Latency: handshake on edge E -> tx low from edge E+1 when block is IDLE and the hold register is empty.
REQ-016 Each bit lasts exactly CLKS_PER_BIT cycles; baud counter decrements each cycle, and a bit boundary occurs when it is 0, when it reloads CLKS_PER_BIT-1.
REQ-017 START -> DATA at the boundary; DATA shifts bits 0..7 LSB first, with tx = current shift LSB; after bit 7 -> STOP (or PARITY under macro).
REQ-018 STOP drives tx=1 for CLKS_PER_BIT cycles; at its boundary: tx_done=1 for one cycle, frame_count increments modulo 256, and the state goes to IDLE.
REQ-019 Back-to-back: a byte accepted during a frame waits in hold; the next START begins the cycle after the STOP boundary (one IDLE cycle with tx=1); no byte is lost or duplicated.
REQ-020 While the hold register is full and a frame is active, result_ready=0; upstream is stalled and must hold its value.
REQ-021 The hold register frees (result_ready rises) on the edge entering START, so a new byte may be accepted during the frame being sent.
REQ-022 busy = (state != IDLE); tx=1 in IDLE.

Reset
REQ-023 rst high at a rising edge: state=IDLE, tx=1, busy=0, tx_done=0, hold_full=0, result_ready=1 in the following cycle, frame_count=0, baud counter=0, bit index=0, shift register=0.
REQ-024 rst mid-frame aborts the frame immediately; the held byte is discarded, and tx_done does not pulse and frame_count does not increment for the aborted frame.
REQ-025 rst takes priority over a simultaneous handshake; the byte is not accepted.

Configuration
REQ-026 Macro RESULT_UART_TX_PARITY_EN defined: a PARITY state is inserted after bit 7, lasting CLKS_PER_BIT cycles, with tx = even parity (XOR of the 8 data bits); frame = 11 bit-times.
REQ-027 Macro undefined: no PARITY state exists; DATA goes directly to STOP; frame = 10 bit-times.

Verification (CLKS_PER_BIT=4)
REQ-028 After reset, send 0xA5 -> tx low from E+1 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; tx_done pulses at cycle E+40; frame_count=1.
REQ-029 Send 0x01 then 0xFF held valid continuously -> second accepted at E+2 while first shifts; both frames are exact, with one idle-high cycle between them; frame_count=2.
REQ-030 Three bytes offered back-to-back -> result_ready low while hold full; the third byte is accepted only after the first START of byte 2; the output order is preserved.
REQ-031 Assert rst during data bit 3 of 0x3C -> next cycle: tx=1, busy=0, result_ready=1, frame_count unchanged (0), and no tx_done pulse.
REQ-032 With RESULT_UART_TX_PARITY_EN, send 0x07 -> parity bit 1, frame 44 cycles; send 0x03 -> parity bit 0.
REQ-033 Send 256 frames -> frame_count wraps to 0, with tx_done pulsing exactly 256 times.
